hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers. It generates the operand-forwarding selects for the EXE-stage ALU inputs, the load-use stall, and the whole-pipeline freeze while a data-memory access in MEM waits on `dmem_ready`. It also keeps a sticky memory-timeout flag and a saturating stall-cycle counter for debug.

## Interface
- `WAIT_MAX`, 8: maximum cycles the pipeline stays frozen on one memory access before timeout (≥2).
- `CNT_W`, 16: width of `stall_cnt`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs`, `rt` in 5: ID-stage source register numbers.
- `rsused`, `rtused` in 1: ID instruction actually reads `rs` / `rt`.
- `ewreg`, `em2reg` in 1: EXE-stage register-write / load controls.
- `edestReg` in 5: EXE-stage destination register.
- `mwreg`, `mm2reg`, `mwmem` in 1: MEM-stage register-write / load / store controls.
- `mdestReg` in 5: MEM-stage destination register.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `dmem_req` out 1: memory access present in MEM (`mm2reg | mwmem`).
- `wpcir` out 1: PC and IF/ID update enable.
- `idexe_bubble` out 1: ID/EXE captures zeroed controls.
- `pipe_en` out 1: ID/EXE and EXE/MEM update enable.
- `memwb_bubble` out 1: MEM/WB captures zeroed controls.
- `fwda`, `fwdb` out 2: ALU operand source for `rs` / `rt`. 00 = regfile, 01 = EXE ALU result, 10 = MEM `mr`, 11 = MEM load data.
- `mem_err` out 1: sticky timeout flag.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `wpcir==0`.

## Operation
- **States:** RUN, WAIT. Internal `wait_cnt` is `clog2(WAIT_MAX)` bits wide.
- **Forwarding (combinational, each operand independently, first match wins):**
  - 01 if `ewreg & ~em2reg & edestReg!=0 & edestReg==src`.
  - 10 if `mwreg & ~mm2reg & mdestReg!=0 & mdestReg==src`.
  - 11 if `mwreg & mm2reg & mdestReg!=0 & mdestReg==src`.
  - Otherwise 00. Register 0 never forwards.
- **Load-use:** `lu = ewreg & em2reg & edestReg!=0 & ((rsused & edestReg==rs) | (rtused & edestReg==rt))`.
- **freeze:**
  - In RUN: `dmem_req & ~dmem_ready`.
  - In WAIT: `~dmem_ready & wait_cnt != WAIT_MAX-1`.
  - Frozen outputs: `wpcir=0`, `pipe_en=0`, `idexe_bubble=0`, `memwb_bubble=1`.
- **Not frozen, lu:** `wpcir=0`, `pipe_en=1`, `idexe_bubble=1`, `memwb_bubble=0`.
- **Otherwise:** `wpcir=1`, `pipe_en=1`, both bubbles 0.
- Freeze takes priority over load-use.
- **Transitions:**
  - RUN→WAIT when `dmem_req & ~dmem_ready`; `wait_cnt` stays 0.
  - WAIT→RUN when `dmem_ready`, or on timeout (`~dmem_ready & wait_cnt==WAIT_MAX-1`).
  - Staying in WAIT increments `wait_cnt`.
  - Entering RUN clears `wait_cnt`.
- **Timeout:** sets `mem_err`, releases the pipeline as if ready, returns to RUN. `mem_err` clears only on `rst`.
- **stall_cnt:** increments on every clock edge where `wpcir==0` and `rst==0`; holds at all-ones.

## Timing
- Forwarding, stall and enable outputs are combinational from inputs and current state; there is no added latency.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM and `lu` deasserts.
- **Memory wait:** at most `WAIT_MAX` frozen cycles; the release cycle is the first cycle with `dmem_ready=1`, or cycle `WAIT_MAX+1` on timeout.
- `dmem_req` stays stable through WAIT, because EXE/MEM is frozen.
- A new access immediately after release may re-enter WAIT on the next cycle; there is no idle gap.
- `dmem_ready` arriving in the same cycle as `dmem_req` in RUN: no freeze, no state change.
- **While `rst` is high:**
  - Outputs: `wpcir=0`, `pipe_en=0`, `idexe_bubble=1`, `memwb_bubble=1`, `fwda=fwdb=00`, `dmem_req=0`.
  - Registers: state RUN, `wait_cnt=0`, `mem_err=0`, `stall_cnt=0`.
  - Reset mid-WAIT aborts the wait immediately.

## Structure
- `mips_pipe_pkg` holds:
  - the state enum `{ST_RUN, ST_WAIT}`;
  - constants `FWD_RF=2'b00`, `FWD_EALU=2'b01`, `FWD_MALU=2'b10`, `FWD_MMEM=2'b11`.
- One sub-module, `fwd_sel`, holds the per-operand priority compare and is instantiated twice (`rs`, `rt`).
- The FSM, counters and enable logic live in `hazard_ctrl`.

## Test plan
- **EXE ALU forward:** `ewreg=1`, `em2reg=0`, `edestReg=5`, `rs=5`, `rt=5`. Expect `fwda=fwdb=01`, `wpcir=1`.
- **Priority and r0:** EXE and MEM both write 7, `rs=7` → `fwda=01`. `edestReg=mdestReg=0`, `rs=0` → `fwda=00`.
- **Load-use:** `ewreg=em2reg=1`, `edestReg=3`, `rt=3`, `rtused=1`. Expect exactly one cycle of `wpcir=0`, `idexe_bubble=1`, `pipe_en=1`. Next cycle, with the load in MEM, `fwdb=11`. `stall_cnt` goes 0→1.
- **Memory wait:** `mm2reg=1`, `dmem_ready` low for 3 cycles then high. Expect 3 cycles of `pipe_en=0`, `memwb_bubble=1`; release on the 4th cycle; `mem_err=0`. This also covers load-use coincident with memory wait: freeze outputs win.
- **Timeout:** `WAIT_MAX=8`, `dmem_ready` held low. Expect 8 frozen cycles, release on cycle 9, `mem_err=1`, with the flag held until `rst`.
- **Reset mid-WAIT:** assert `rst` asynchronously. Expect immediate RUN, counters 0, `wpcir=0`, both bubbles 1. Separately, force `stall_cnt` to saturation and confirm it holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Holds the memory-wait FSM states and the ALU operand-forwarding select codes.
package mips_pipe_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the hazard controller.
// slave = the controller's view, master = the pipeline's view.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rsused;
  logic             rtused;
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       edestReg;
  logic             mwreg;
  logic             mm2reg;
  logic             mwmem;
  logic [4:0]       mdestReg;
  logic             dmem_ready;
  logic             dmem_req;
  logic             wpcir;
  logic             idexe_bubble;
  logic             pipe_en;
  logic             memwb_bubble;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  rs, rt, rsused, rtused, ewreg, em2reg, edestReg,
           mwreg, mm2reg, mwmem, mdestReg, dmem_ready,
    output dmem_req, wpcir, idexe_bubble, pipe_en, memwb_bubble,
           fwda, fwdb, mem_err, stall_cnt
  );

  modport master (
    output rs, rt, rsused, rtused, ewreg, em2reg, edestReg,
           mwreg, mm2reg, mwmem, mdestReg, dmem_ready,
    input  dmem_req, wpcir, idexe_bubble, pipe_en, memwb_bubble,
           fwda, fwdb, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: nearest producer wins, register 0 never forwards.
module fwd_sel
  import mips_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] edestReg,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mdestReg,
  output logic [1:0] fwd
);
  logic e_hit;
  logic m_hit;

  always_comb begin
    e_hit = (edestReg != 5'd0) && (edestReg == src);
    m_hit = (mdestReg != 5'd0) && (mdestReg == src);
    fwd   = FWD_RF;
    if (ewreg && !em2reg && e_hit)     fwd = FWD_EALU;
    else if (mwreg && !mm2reg && m_hit) fwd = FWD_MALU;
    else if (mwreg && mm2reg && m_hit)  fwd = FWD_MMEM;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, load-use stall, memory-wait freeze
// with timeout, sticky timeout flag and saturating stall-cycle counter.
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);
  localparam int             WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] fwda_raw, fwdb_raw, fwda_w, fwdb_w;
  logic       req, lu, freeze, timeout;
  logic       wpcir_w, pipe_en_w, idexe_bubble_w, memwb_bubble_w, dmem_req_w;

  fwd_sel u_fwd_rs (
    .src(bus.rs), .ewreg(bus.ewreg), .em2reg(bus.em2reg), .edestReg(bus.edestReg),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mdestReg(bus.mdestReg), .fwd(fwda_raw)
  );

  fwd_sel u_fwd_rt (
    .src(bus.rt), .ewreg(bus.ewreg), .em2reg(bus.em2reg), .edestReg(bus.edestReg),
    .mwreg(bus.mwreg), .mm2reg(bus.mm2reg), .mdestReg(bus.mdestReg), .fwd(fwdb_raw)
  );

  always_comb begin
    req     = bus.mm2reg | bus.mwmem;
    lu      = bus.ewreg & bus.em2reg & (bus.edestReg != 5'd0) &
              ((bus.rsused & (bus.edestReg == bus.rs)) |
               (bus.rtused & (bus.edestReg == bus.rt)));
    timeout = (state_q == ST_WAIT) && !bus.dmem_ready && (wait_cnt_q == WAIT_LAST);
    freeze  = (state_q == ST_RUN) ? (req & ~bus.dmem_ready)
                                  : (~bus.dmem_ready & (wait_cnt_q != WAIT_LAST));

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q | timeout;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (req && !bus.dmem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.dmem_ready || timeout) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    wpcir_w        = 1'b1;
    pipe_en_w      = 1'b1;
    idexe_bubble_w = 1'b0;
    memwb_bubble_w = 1'b0;
    fwda_w         = fwda_raw;
    fwdb_w         = fwdb_raw;
    dmem_req_w     = req;
    if (freeze) begin
      wpcir_w        = 1'b0;
      pipe_en_w      = 1'b0;
      memwb_bubble_w = 1'b1;
    end else if (lu) begin
      wpcir_w        = 1'b0;
      idexe_bubble_w = 1'b1;
    end
    // Reset holds the whole pipeline quiet regardless of what the stages present.
    if (rst) begin
      wpcir_w        = 1'b0;
      pipe_en_w      = 1'b0;
      idexe_bubble_w = 1'b1;
      memwb_bubble_w = 1'b1;
      fwda_w         = FWD_RF;
      fwdb_w         = FWD_RF;
      dmem_req_w     = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!wpcir_w && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.dmem_req     = dmem_req_w;
  assign bus.wpcir        = wpcir_w;
  assign bus.idexe_bubble = idexe_bubble_w;
  assign bus.pipe_en      = pipe_en_w;
  assign bus.memwb_bubble = memwb_bubble_w;
  assign bus.fwda         = fwda_w;
  assign bus.fwdb         = fwdb_w;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, memory wait, timeout,
// asynchronous reset mid-wait and stall counter saturation (narrow second instance).
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(16)) hif ();
  hazard_ctrl_if #(.CNT_W(4))  hsat ();

  hazard_ctrl #(.WAIT_MAX(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(hif));
  hazard_ctrl #(.WAIT_MAX(8), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(hsat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.rs = 5'd0; hif.rt = 5'd0; hif.rsused = 1'b0; hif.rtused = 1'b0;
    hif.ewreg = 1'b0; hif.em2reg = 1'b0; hif.edestReg = 5'd0;
    hif.mwreg = 1'b0; hif.mm2reg = 1'b0; hif.mwmem = 1'b0; hif.mdestReg = 5'd0;
    hif.dmem_ready = 1'b1;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    clr();
    hsat.rs = 5'd0; hsat.rt = 5'd0; hsat.rsused = 1'b0; hsat.rtused = 1'b0;
    hsat.ewreg = 1'b0; hsat.em2reg = 1'b0; hsat.edestReg = 5'd0;
    hsat.mwreg = 1'b0; hsat.mm2reg = 1'b0; hsat.mwmem = 1'b0; hsat.mdestReg = 5'd0;
    hsat.dmem_ready = 1'b1;

    // Reset: outputs forced quiet even with a forwardable load presented
    hif.mm2reg = 1'b1; hif.mwreg = 1'b1; hif.mdestReg = 5'd9; hif.rs = 5'd9;
    hif.dmem_ready = 1'b0;
    tick(); tick();
    chk("rst_wpcir", hif.wpcir, 0);
    chk("rst_pipe_en", hif.pipe_en, 0);
    chk("rst_idexe_bubble", hif.idexe_bubble, 1);
    chk("rst_memwb_bubble", hif.memwb_bubble, 1);
    chk("rst_fwda", hif.fwda, 0);
    chk("rst_dmem_req", hif.dmem_req, 0);
    chk("rst_stall_cnt", hif.stall_cnt, 0);
    chk("rst_mem_err", hif.mem_err, 0);
    clr();
    rst = 1'b0;
    #1;

    // EXE ALU forward on both operands
    hif.ewreg = 1'b1; hif.edestReg = 5'd5; hif.rs = 5'd5; hif.rt = 5'd5;
    #1;
    chk("ealu_fwda", hif.fwda, 2'b01);
    chk("ealu_fwdb", hif.fwdb, 2'b01);
    chk("ealu_wpcir", hif.wpcir, 1);

    // Priority: EXE beats MEM, then MEM ALU, then MEM load, r0 never forwards
    clr();
    hif.ewreg = 1'b1; hif.edestReg = 5'd7; hif.mwreg = 1'b1; hif.mdestReg = 5'd7;
    hif.rs = 5'd7; hif.rt = 5'd7;
    #1;
    chk("prio_fwda_exe", hif.fwda, 2'b01);
    hif.ewreg = 1'b0;
    #1;
    chk("prio_fwda_malu", hif.fwda, 2'b10);
    hif.mm2reg = 1'b1;
    #1;
    chk("prio_fwdb_mmem", hif.fwdb, 2'b11);
    hif.ewreg = 1'b1; hif.mm2reg = 1'b0; hif.edestReg = 5'd0; hif.mdestReg = 5'd0;
    hif.rs = 5'd0;
    #1;
    chk("r0_fwda", hif.fwda, 2'b00);

    // Load-use: one stall cycle, then MEM load data forwarded
    clr();
    hif.ewreg = 1'b1; hif.em2reg = 1'b1; hif.edestReg = 5'd3; hif.rt = 5'd3; hif.rtused = 1'b1;
    #1;
    chk("lu_wpcir", hif.wpcir, 0);
    chk("lu_idexe_bubble", hif.idexe_bubble, 1);
    chk("lu_pipe_en", hif.pipe_en, 1);
    chk("lu_memwb_bubble", hif.memwb_bubble, 0);
    chk("lu_stall_cnt0", hif.stall_cnt, 0);
    tick();
    clr();
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mdestReg = 5'd3; hif.rt = 5'd3; hif.rtused = 1'b1;
    #1;
    chk("lu_next_fwdb", hif.fwdb, 2'b11);
    chk("lu_next_wpcir", hif.wpcir, 1);
    chk("lu_stall_cnt1", hif.stall_cnt, 1);

    // Memory wait of 3 cycles with a coincident load-use; freeze wins
    hif.dmem_ready = 1'b0;
    hif.ewreg = 1'b1; hif.em2reg = 1'b1; hif.edestReg = 5'd4; hif.rs = 5'd4; hif.rsused = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mw_pipe_en_c%0d", i + 1), hif.pipe_en, 0);
      chk($sformatf("mw_memwb_bubble_c%0d", i + 1), hif.memwb_bubble, 1);
      chk($sformatf("mw_idexe_bubble_c%0d", i + 1), hif.idexe_bubble, 0);
      tick();
    end
    hif.dmem_ready = 1'b1;
    #1;
    chk("mw_release_pipe_en", hif.pipe_en, 1);
    chk("mw_release_memwb_bubble", hif.memwb_bubble, 0);
    chk("mw_release_lu_bubble", hif.idexe_bubble, 1);
    chk("mw_mem_err", hif.mem_err, 0);
    chk("mw_stall_cnt", hif.stall_cnt, 4);
    tick();

    // Timeout: 8 frozen cycles, release on cycle 9, sticky error
    clr();
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mdestReg = 5'd6; hif.dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_pipe_en_c%0d", i + 1), hif.pipe_en, 0);
      tick();
    end
    chk("to_release_pipe_en", hif.pipe_en, 1);
    chk("to_release_wpcir", hif.wpcir, 1);
    chk("to_release_memwb_bubble", hif.memwb_bubble, 0);
    chk("to_stall_cnt", hif.stall_cnt, 13);
    tick();
    chk("to_mem_err", hif.mem_err, 1);
    chk("to_reenter_pipe_en", hif.pipe_en, 0);
    tick();
    tick();
    chk("to_mem_err_held", hif.mem_err, 1);
    chk("to_wait_pipe_en", hif.pipe_en, 0);

    // Asynchronous reset in the middle of a wait
    #1;
    rst = 1'b1;
    #1;
    chk("arst_wpcir", hif.wpcir, 0);
    chk("arst_idexe_bubble", hif.idexe_bubble, 1);
    chk("arst_memwb_bubble", hif.memwb_bubble, 1);
    chk("arst_stall_cnt", hif.stall_cnt, 0);
    chk("arst_mem_err", hif.mem_err, 0);
    hif.mm2reg = 1'b0; hif.mwreg = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_run_pipe_en", hif.pipe_en, 1);
    chk("arst_run_wpcir", hif.wpcir, 1);

    // Ready in the same cycle as the request: no freeze, stays in RUN
    tick();
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mdestReg = 5'd8; hif.dmem_ready = 1'b1;
    #1;
    chk("rdy_same_pipe_en", hif.pipe_en, 1);
    tick();
    hif.mm2reg = 1'b0; hif.mwreg = 1'b0; hif.dmem_ready = 1'b0;
    #1;
    chk("rdy_same_stays_run", hif.pipe_en, 1);
    chk("rdy_same_stall_cnt", hif.stall_cnt, 0);

    // Saturation on a 4-bit counter held in continuous load-use
    hsat.ewreg = 1'b1; hsat.em2reg = 1'b1; hsat.edestReg = 5'd2; hsat.rs = 5'd2; hsat.rsused = 1'b1;
    #1;
    chk("sat_start", hsat.stall_cnt, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_reach", hsat.stall_cnt, 4'hF);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold", hsat.stall_cnt, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
